// File: rtl/tmr16_ctrl.sv
// 16-bit up-counting timer with a 4-bit prescaler and one-shot or periodic
// auto-reload. The terminal count pulse (TC) is registered and lasts one cycle.
module tmr16_ctrl (
    input  logic        CLK,
    input  logic        CD,
    input  logic        START,
    input  logic        STOP,
    input  logic        MODE,
    input  logic [15:0] LOADV,
    input  logic [3:0]  PS,
    output logic [15:0] Q,
    output logic        BUSY,
    output logic        TC
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t     state;
    logic [3:0] pre;

    // Four chained nibble incrementers. A nibble steps only when every lower
    // nibble is 4'hF.
    function automatic logic [15:0] nib_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int n = 0; n < 4; n++) begin
            r[n*4 +: 4] = v[n*4 +: 4] + {3'b000, carry};
            carry       = carry & (v[n*4 +: 4] == 4'hF);
        end
        return r;
    endfunction

    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            state <= S_IDLE;
            Q     <= 16'h0000;
            pre   <= 4'h0;
            BUSY  <= 1'b0;
            TC    <= 1'b0;
        end else begin
            TC <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!STOP && START) begin
                        state <= S_LOAD;
                        BUSY  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (STOP) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        Q     <= LOADV;
                        pre   <= PS;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end else if (START) begin
                        state <= S_LOAD;
                    end else if (pre == 4'hF) begin
                        pre <= PS;
                        if (Q == 16'hFFFF) begin
                            // Terminal tick: periodic mode reloads instead of wrapping to zero.
                            TC <= 1'b1;
                            if (MODE) begin
                                Q <= LOADV;
                            end else begin
                                state <= S_IDLE;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            Q <= nib_inc(Q);
                        end
                    end else begin
                        pre <= pre + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr16_ctrl.sv
// Directed bench for tmr16_ctrl: a cycle-countdown reference model is checked
// against the DUT on every falling edge, plus hand-computed literal checks.
module tb_tmr16_ctrl;

    logic        CLK = 1'b0;
    logic        CD = 1'b1;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        MODE = 1'b0;
    logic [15:0] LOADV = 16'h0000;
    logic [3:0]  PS = 4'h0;
    logic [15:0] Q;
    logic        BUSY;
    logic        TC;

    bit clk_en = 1'b1;
    bit cmp_en = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    tmr16_ctrl dut (
        .CLK(CLK), .CD(CD), .START(START), .STOP(STOP), .MODE(MODE),
        .LOADV(LOADV), .PS(PS), .Q(Q), .BUSY(BUSY), .TC(TC)
    );

    always #5 if (clk_en) CLK = ~CLK;

    // Reference model: phase 0 idle, 1 loading, 2 running; m_left counts
    // the cycles remaining until the next tick.
    logic [15:0] m_q;
    bit          m_busy, m_tc;
    int          m_phase, m_left;

    always @(posedge CLK or posedge CD) begin
        int          ph, left;
        logic [15:0] q;
        bit          tc;
        if (CD) begin
            m_q     <= 16'h0000;
            m_busy  <= 1'b0;
            m_tc    <= 1'b0;
            m_phase <= 0;
            m_left  <= 0;
        end else begin
            ph = m_phase; left = m_left; q = m_q; tc = 1'b0;
            if (STOP) begin
                ph = 0;
            end else if (ph == 0) begin
                if (START) ph = 1;
            end else if (ph == 1) begin
                q = LOADV; left = 16 - int'(PS); ph = 2;
            end else if (START) begin
                ph = 1;
            end else begin
                left = left - 1;
                if (left == 0) begin
                    left = 16 - int'(PS);
                    if (q == 16'hFFFF) begin
                        tc = 1'b1;
                        if (MODE) q = LOADV;
                        else ph = 0;
                    end else begin
                        q = q + 16'd1;
                    end
                end
            end
            m_q     <= q;
            m_tc    <= tc;
            m_phase <= ph;
            m_left  <= left;
            m_busy  <= (ph != 0);
        end
    end

    always @(negedge CLK) begin
        if (cmp_en && !CD) begin
            n_vec++;
            if (Q !== m_q || BUSY !== m_busy || TC !== m_tc) begin
                n_err++;
                $display("FAIL model @%0t: got Q=%h BUSY=%b TC=%b expected Q=%h BUSY=%b TC=%b",
                         $time, Q, BUSY, TC, m_q, m_busy, m_tc);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic kick(input logic [15:0] lv, input logic [3:0] ps, input logic md);
        LOADV = lv; PS = ps; MODE = md; START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic halt();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc_cnt;
        #2;
        chk("reset_q", Q, 16'h0000);
        chk("reset_busy", 16'(BUSY), 16'h0);
        chk("reset_tc", 16'(TC), 16'h0);
        @(negedge CLK);
        CD = 1'b0;
        cmp_en = 1'b1;
        step(2);

        // One-shot from FFFE at full rate
        kick(16'hFFFE, 4'hF, 1'b0);
        chk("os_load_busy", 16'(BUSY), 16'h1);
        step(); chk("os_q_e2", Q, 16'hFFFE);
        step(); chk("os_q_e3", Q, 16'hFFFF); chk("os_tc_e3", 16'(TC), 16'h0);
        step(); chk("os_tc_e4", 16'(TC), 16'h1); chk("os_busy_e4", 16'(BUSY), 16'h0);
        chk("os_q_e4", Q, 16'hFFFF);
        step(); chk("os_tc_e5", 16'(TC), 16'h0); chk("os_q_e5", Q, 16'hFFFF);

        // Periodic from FFFD, tick every 2 cycles
        kick(16'hFFFD, 4'hE, 1'b1);
        step(); chk("per_q_e2", Q, 16'hFFFD);
        tc_cnt = 0;
        for (int e = 3; e <= 20; e++) begin
            step();
            if (TC) tc_cnt++;
            if (e == 3) chk("per_q_e3", Q, 16'hFFFD);
            if (e == 4) chk("per_q_e4", Q, 16'hFFFE);
            if (e == 8) chk("per_tc_e8", 16'(TC), 16'h1);
            if (e == 9) chk("per_q_e9", Q, 16'hFFFD);
        end
        chk("per_tc_count", 16'(tc_cnt), 16'd3);
        chk("per_q_e20", Q, 16'hFFFD);
        halt();
        chk("per_stop_busy", 16'(BUSY), 16'h0);

        // Nibble carry propagation
        kick(16'h00FF, 4'hF, 1'b0);
        step(); chk("carry_00ff", Q, 16'h00FF);
        step(); chk("carry_0100", Q, 16'h0100);
        halt();
        kick(16'h0FFF, 4'hF, 1'b0);
        step(); chk("carry_0fff", Q, 16'h0FFF);
        step(); chk("carry_1000", Q, 16'h1000);
        halt();

        // STOP and START together while running
        kick(16'h0000, 4'hF, 1'b0);
        step(2);
        chk("ss_q_before", Q, 16'h0001);
        STOP = 1'b1; START = 1'b1;
        step();
        STOP = 1'b0; START = 1'b0;
        chk("ss_busy", 16'(BUSY), 16'h0); chk("ss_q", Q, 16'h0001);
        step(); chk("ss_q_hold", Q, 16'h0001);

        // STOP on the terminal-tick edge suppresses TC
        kick(16'hFFFF, 4'hF, 1'b1);
        step(); chk("tstop_q", Q, 16'hFFFF);
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk("tstop_tc", 16'(TC), 16'h0); chk("tstop_busy", 16'(BUSY), 16'h0);
        chk("tstop_qh", Q, 16'hFFFF);

        // Restart on the terminal-tick edge suppresses TC
        kick(16'hFFFF, 4'hF, 1'b1);
        step();
        LOADV = 16'h0005; START = 1'b1;
        step();
        START = 1'b0;
        chk("trst_tc", 16'(TC), 16'h0); chk("trst_busy", 16'(BUSY), 16'h1);
        step(); chk("trst_q", Q, 16'h0005);
        halt();

        // Restart mid-run with a new value and slower prescale
        kick(16'h0010, 4'hF, 1'b0);
        step(3);
        chk("rl_q_before", Q, 16'h0012);
        LOADV = 16'h1234; PS = 4'hD; START = 1'b1;
        step();
        START = 1'b0;
        chk("rl_load_q", Q, 16'h0012); chk("rl_load_busy", 16'(BUSY), 16'h1);
        step(); chk("rl_q", Q, 16'h1234);
        step(2); chk("rl_q_p2", Q, 16'h1234);
        step(); chk("rl_q_p3", Q, 16'h1235);
        halt();

        // Asynchronous reset with the clock stopped
        kick(16'h0100, 4'hF, 1'b0);
        step(2);
        chk("ar_q_before", Q, 16'h0101);
        clk_en = 1'b0;
        #7 CD = 1'b1;
        #1;
        chk("ar_q", Q, 16'h0000);
        chk("ar_busy", 16'(BUSY), 16'h0);
        chk("ar_tc", 16'(TC), 16'h0);
        #5 CD = 1'b0;
        #3 clk_en = 1'b1;
        step();
        chk("ar_idle_q", Q, 16'h0000); chk("ar_idle_busy", 16'(BUSY), 16'h0);
        kick(16'hABCD, 4'hF, 1'b0);
        step(); chk("ar_restart_q", Q, 16'hABCD);
        halt();
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
